spectrum_uart_dumper: RTL and testbench

SPECTRUM_UART_DUMPER -- requirements
Module: spectrum_uart_dumper

---
 rtl/spectrum_uart_dumper_pkg.sv | 33 +++
 rtl/spectrum_uart_dumper.sv | 158 +++++++++++++++
 tb/tb_spectrum_uart_dumper.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_uart_dumper_pkg.sv
// Shared definitions for the spectrum UART dumper: FSM state encoding,
// byte-phase encoding, and default frame geometry / sync bytes.
// No logic lives here; the top imports everything it needs.
package spectrum_uart_dumper_pkg;

  localparam int         DEF_N_BINS = 512;
  localparam logic [7:0] DEF_HDR0   = 8'hA5;
  localparam logic [7:0] DEF_HDR1   = 8'h5A;

  // Bin index is one bit wider than the RAM address so a 512-bin frame
  // can count to 512 and terminate without wrapping back to 0.
  localparam int IDX_W  = 10;
  localparam int ADDR_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_CAPT,
    S_SEND,
    S_HOLD,
    S_DRAIN
  } state_e;

  // Which byte of the frame is currently in flight.
  typedef enum logic [1:0] {
    PH_HDR0,
    PH_HDR1,
    PH_BIN,
    PH_CSUM
  } phase_e;

endpackage

// File: rtl/spectrum_uart_dumper.sv
// Streams one spectrum frame (HDR0, HDR1, N_BINS bins, 8-bit checksum) to an external UART.
// Latency: first tx_start two cycles after an accepted trigger; one byte per UART busy period.
// Backpressure: each byte waits in DRAIN for tx_busy to fall; no timeout while tx_busy is stuck.
module spectrum_uart_dumper
  import spectrum_uart_dumper_pkg::*;
#(
  parameter int         N_BINS = DEF_N_BINS,
  parameter logic [7:0] HDR0   = DEF_HDR0,
  parameter logic [7:0] HDR1   = DEF_HDR1
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [7:0]        ram_dout,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);

  state_e              state_q;
  phase_e              phase_q;
  logic [IDX_W-1:0]    idx_q;
  logic [7:0]          csum_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                tx_start_q;
  logic [7:0]          tx_data_q;
  logic                busy_q;
  logic                overrun_q;
  logic [7:0]          frame_cnt_q;

  logic [IDX_W-1:0]    idx_d;
  logic [7:0]          csum_d;
  logic                last_bin;

  // Next bin index, running checksum including the byte arriving from the RAM,
  // and whether the bin just sent was the final one of the frame.
  always_comb begin
    idx_d    = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    csum_d   = csum_q + ram_dout;
    last_bin = (int'({{(32-IDX_W){1'b0}}, idx_d}) >= N_BINS);
  end

  // Frame sequencer with registered outputs. tx_start is raised on the edge
  // that enters SEND so it is high for exactly the SEND cycle. ram_addr is
  // loaded on the edge entering FETCH so the RAM sees the address during
  // FETCH and its data is ready to latch in CAPT.
  always_ff @(posedge cclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_HDR0;
      idx_q       <= '0;
      csum_q      <= 8'h00;
      ram_addr_q  <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;

      // A request while a frame is in flight (including its final DRAIN
      // cycle) is dropped and remembered until the next reset.
      if (trigger && busy_q) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            csum_q  <= 8'h00;
            idx_q   <= '0;
            phase_q <= PH_HDR0;
            busy_q  <= 1'b1;
            state_q <= S_HDR;
          end
        end

        S_HDR: begin
          tx_data_q  <= (phase_q == PH_HDR0) ? HDR0 : HDR1;
          tx_start_q <= 1'b1;
          state_q    <= S_SEND;
        end

        S_FETCH: begin
          ram_addr_q <= idx_q[ADDR_W-1:0];
          state_q    <= S_CAPT;
        end

        S_CAPT: begin
          tx_data_q  <= ram_dout;
          csum_q     <= csum_d;
          tx_start_q <= 1'b1;
          state_q    <= S_SEND;
        end

        S_SEND: begin
          state_q <= S_HOLD;
        end

        // The UART may take a cycle to raise tx_busy, so it is not looked at here.
        S_HOLD: begin
          state_q <= S_DRAIN;
        end

        S_DRAIN: begin
          if (!tx_busy) begin
            case (phase_q)
              PH_HDR0: begin
                phase_q <= PH_HDR1;
                state_q <= S_HDR;
              end
              PH_HDR1: begin
                phase_q    <= PH_BIN;
                idx_q      <= '0;
                ram_addr_q <= '0;
                state_q    <= S_FETCH;
              end
              PH_BIN: begin
                idx_q <= idx_d;
                if (last_bin) begin
                  tx_data_q  <= csum_q;
                  tx_start_q <= 1'b1;
                  phase_q    <= PH_CSUM;
                  state_q    <= S_SEND;
                end else begin
                  ram_addr_q <= idx_d[ADDR_W-1:0];
                  state_q    <= S_FETCH;
                end
              end
              default: begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                busy_q      <= 1'b0;
                state_q     <= S_IDLE;
              end
            endcase
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spectrum_uart_dumper.sv
// Bench for spectrum_uart_dumper: a default 512-bin instance for frame content,
// checksum, overrun and reset behaviour, plus a 2-bin instance for frame_cnt wrap.
// Expected frames are built from RAM contents with plain arithmetic.
`timescale 1ns/1ps
module tb_spectrum_uart_dumper;

  localparam int N0 = 512;
  localparam int N1 = 2;

  logic cclk = 1'b0;
  always #5 cclk = ~cclk;

  logic       reset;
  logic       trig0, trig1;
  logic [7:0] ram_dout0, ram_dout1;
  logic       tx_busy0 = 1'b0;
  logic       tx_busy1 = 1'b0;
  logic [8:0] ram_addr0, ram_addr1;
  logic       tx_start0, tx_start1;
  logic [7:0] tx_data0, tx_data1;
  logic       busy0, busy1, ovr0, ovr1;
  logic [7:0] fc0, fc1;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  logic [7:0] rx0[$];
  logic [7:0] rx1[$];
  logic [7:0] exp0[$];

  int cnt0 = 0;
  int cnt1 = 0;
  int fix_len0 = 1;
  int viol = 0;
  int hold_err = 0;
  int n_vec = 0;
  int n_miss = 0;
  int exp_fc0 = 0;

  spectrum_uart_dumper dut0 (
    .cclk(cclk), .reset(reset), .trigger(trig0), .ram_dout(ram_dout0), .tx_busy(tx_busy0),
    .ram_addr(ram_addr0), .tx_start(tx_start0), .tx_data(tx_data0), .busy(busy0),
    .overrun(ovr0), .frame_cnt(fc0)
  );

  spectrum_uart_dumper #(.N_BINS(N1)) dut1 (
    .cclk(cclk), .reset(reset), .trigger(trig1), .ram_dout(ram_dout1), .tx_busy(tx_busy1),
    .ram_addr(ram_addr1), .tx_start(tx_start1), .tx_data(tx_data1), .busy(busy1),
    .overrun(ovr1), .frame_cnt(fc1)
  );

  // Synchronous spectrum caches: data one cycle after the address.
  always @(posedge cclk) begin
    ram_dout0 <= mem0[ram_addr0];
    ram_dout1 <= mem1[ram_addr1];
  end

  // UART models: capture each launched byte, stay busy for a number of cycles,
  // and flag launches while busy or tx_data changing while busy.
  always @(negedge cclk) begin
    if (tx_start0) begin
      if (tx_busy0) viol++;
      rx0.push_back(tx_data0);
      tx_busy0 = 1'b1;
      cnt0 = (fix_len0 > 0) ? fix_len0 : int'($urandom_range(4, 1));
    end else if (cnt0 > 0) begin
      if (busy0 && rx0.size() > 0 && tx_data0 !== rx0[rx0.size()-1]) hold_err++;
      cnt0--;
      if (cnt0 == 0) tx_busy0 = 1'b0;
    end
    if (tx_start1) begin
      if (tx_busy1) viol++;
      rx1.push_back(tx_data1);
      tx_busy1 = 1'b1;
      cnt1 = 1;
    end else if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) tx_busy1 = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp0();
    int sum;
    sum = 0;
    exp0.delete();
    exp0.push_back(8'hA5);
    exp0.push_back(8'h5A);
    for (int i = 0; i < N0; i++) begin
      exp0.push_back(mem0[i]);
      sum += int'(mem0[i]);
    end
    exp0.push_back(8'(sum % 256));
  endtask

  function automatic logic [31:0] last_rx0();
    return (rx0.size() > 0) ? {24'd0, rx0[rx0.size()-1]} : 32'hFFFF_FFFF;
  endfunction

  task automatic cmp_frame0(input string tag);
    check({tag, "_len"}, rx0.size(), exp0.size());
    for (int i = 0; i < exp0.size() && i < rx0.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx0[i]}, {24'd0, exp0[i]});
    check({tag, "_frame_cnt"}, {24'd0, fc0}, exp_fc0 & 255);
  endtask

  task automatic start0(input string tag);
    int lat;
    rx0.delete();
    trig0 = 1'b1;
    @(negedge cclk);
    trig0 = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy0}, 1);
    lat = 1;
    while (!tx_start0 && lat < 8) begin
      @(negedge cclk);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
  endtask

  task automatic wait_idle0(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 20000) begin
      @(negedge cclk);
      n++;
    end
    check({tag, "_done"}, {31'd0, busy0}, 0);
  endtask

  task automatic wait_rx0(input string tag, input int target);
    int n;
    n = 0;
    while (rx0.size() < target && n < 20000) begin
      @(negedge cclk);
      n++;
    end
    check({tag, "_reach"}, (rx0.size() >= target) ? 1 : 0, 1);
  endtask

  task automatic run_frame0(input string tag, input int len);
    fix_len0 = len;
    build_exp0();
    start0(tag);
    wait_idle0(tag);
    @(negedge cclk);
    exp_fc0++;
    cmp_frame0(tag);
  endtask

  task automatic fill_rand0();
    for (int i = 0; i < N0; i++) mem0[i] = 8'($urandom_range(255, 0));
  endtask

  initial begin
    int n;
    int n_rx;
    int sum1;
    reset = 1'b1;
    trig0 = 1'b0;
    trig1 = 1'b0;
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'($urandom_range(255, 0));
    end
    repeat (3) @(negedge cclk);

    check("rst_tx_start", {31'd0, tx_start0}, 0);
    check("rst_tx_data", {24'd0, tx_data0}, 0);
    check("rst_ram_addr", {23'd0, ram_addr0}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_overrun", {31'd0, ovr0}, 0);
    check("rst_frame_cnt", {24'd0, fc0}, 0);
    reset = 1'b0;
    @(negedge cclk);

    // Ramp bins, slow UART: two full 00..FF sweeps, checksum 0.
    for (int i = 0; i < N0; i++) mem0[i] = i[7:0];
    run_frame0("ramp", 10);
    check("ramp_csum", last_rx0(), 32'h00);
    check("ramp_overrun", {31'd0, ovr0}, 0);

    for (int i = 0; i < N0; i++) mem0[i] = 8'h01;
    run_frame0("ones", 0);
    check("ones_csum", last_rx0(), 32'h00);

    for (int i = 0; i < N0; i++) mem0[i] = 8'h03;
    run_frame0("threes", 0);
    check("threes_csum", last_rx0(), 32'h00);

    for (int i = 0; i < N0; i++) mem0[i] = 8'h00;
    mem0[0] = 8'h07;
    run_frame0("seven", 0);
    check("seven_csum", last_rx0(), 32'h07);

    fill_rand0();
    run_frame0("rand", 0);

    // Re-trigger in the middle of a frame: frame intact, overrun set, no restart.
    fill_rand0();
    fix_len0 = 0;
    build_exp0();
    start0("ovr");
    wait_rx0("ovr", 101);
    trig0 = 1'b1;
    @(negedge cclk);
    trig0 = 1'b0;
    wait_idle0("ovr");
    @(negedge cclk);
    exp_fc0++;
    cmp_frame0("ovr");
    check("ovr_flag", {31'd0, ovr0}, 1);
    repeat (6) @(negedge cclk);
    check("ovr_no_restart_busy", {31'd0, busy0}, 0);
    check("ovr_no_restart_rx", rx0.size(), N0 + 3);

    // Reset while bin 37 is on the wire.
    fill_rand0();
    build_exp0();
    start0("rst");
    wait_rx0("rst", 40);
    reset = 1'b1;
    @(negedge cclk);
    check("rst_mid_tx_start", {31'd0, tx_start0}, 0);
    check("rst_mid_busy", {31'd0, busy0}, 0);
    check("rst_mid_frame_cnt", {24'd0, fc0}, 0);
    check("rst_mid_overrun", {31'd0, ovr0}, 0);
    reset = 1'b0;
    exp_fc0 = 0;
    n_rx = rx0.size();
    repeat (4) @(negedge cclk);
    check("rst_mid_quiet", rx0.size(), n_rx);
    n = 0;
    while (tx_busy0 && n < 50) begin
      @(negedge cclk);
      n++;
    end
    run_frame0("post_rst", 0);
    check("post_rst_first", (rx0.size() > 0) ? {24'd0, rx0[0]} : 32'hFFFF_FFFF, 32'hA5);
    check("post_rst_overrun", {31'd0, ovr0}, 0);

    // Trigger held high through the final DRAIN exit: overrun, no new frame.
    fill_rand0();
    build_exp0();
    start0("coin");
    wait_rx0("coin", N0 + 3);
    trig0 = 1'b1;
    n = 0;
    while (busy0 && n < 100) begin
      @(negedge cclk);
      n++;
    end
    trig0 = 1'b0;
    exp_fc0++;
    repeat (4) @(negedge cclk);
    cmp_frame0("coin");
    check("coin_overrun", {31'd0, ovr0}, 1);
    check("coin_idle", {31'd0, busy0}, 0);

    // 256 back-to-back frames on the 2-bin instance: counter wraps to 0.
    for (int f = 0; f < 256; f++) begin
      rx1.delete();
      trig1 = 1'b1;
      @(negedge cclk);
      trig1 = 1'b0;
      n = 0;
      while (busy1 && n < 200) begin
        @(negedge cclk);
        n++;
      end
      check($sformatf("wrap_cnt%0d", f), {24'd0, fc1}, (f + 1) % 256);
    end
    sum1 = int'(mem1[0]) + int'(mem1[1]);
    check("wrap_len", rx1.size(), 5);
    if (rx1.size() == 5) begin
      check("wrap_b0", {24'd0, rx1[0]}, 32'hA5);
      check("wrap_b1", {24'd0, rx1[1]}, 32'h5A);
      check("wrap_b2", {24'd0, rx1[2]}, {24'd0, mem1[0]});
      check("wrap_b3", {24'd0, rx1[3]}, {24'd0, mem1[1]});
      check("wrap_csum", {24'd0, rx1[4]}, sum1 % 256);
    end
    check("wrap_overrun", {31'd0, ovr1}, 0);

    check("start_while_tx_busy", viol, 0);
    check("tx_data_hold", hold_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
